// File: rtl/player_input_ctrl.sv
// Player input controller.
// Converts the two raw USB keycode slots into per-frame movement commands
// (direction plus a buffered jump request) for two independent players.
// Keys are sampled once per VGA frame on a synchronized frame_clk rising edge.

// One player's command path: direction FSM and jump request buffer.
module player_input_lane #(
  parameter logic [7:0]  LEFT_KC         = 8'h04,
  parameter logic [7:0]  RIGHT_KC        = 8'h07,
  parameter logic [7:0]  JUMP_KC         = 8'h1A,
  parameter int unsigned JUMP_BUF_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_tick,
  input  logic [7:0] i_kc0,
  input  logic [7:0] i_kc1,
  input  logic       i_jump_ack,
  output logic [1:0] o_dir,
  output logic       o_jump_req
);

  // The state encoding doubles as the dir output encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RIGHT = 2'b01,
    S_LEFT  = 2'b10
  } dir_e;

  localparam logic [3:0] BUF_LOAD = 4'(JUMP_BUF_FRAMES);

  dir_e       r_state;
  dir_e       w_state_nxt;
  logic [1:0] r_dir;
  logic       r_prev_l;
  logic       r_prev_r;
  logic       r_prev_j;
  logic       r_jump_req;
  logic [3:0] r_cnt;

  logic w_l;
  logic w_r;
  logic w_j;
  logic w_l_new;
  logic w_r_new;
  logic w_j_edge;

  // A key counts as pressed if it sits in either USB slot.
  assign w_l      = (i_kc0 == LEFT_KC)  | (i_kc1 == LEFT_KC);
  assign w_r      = (i_kc0 == RIGHT_KC) | (i_kc1 == RIGHT_KC);
  assign w_j      = (i_kc0 == JUMP_KC)  | (i_kc1 == JUMP_KC);
  assign w_l_new  = w_l & ~r_prev_l;
  assign w_r_new  = w_r & ~r_prev_r;
  assign w_j_edge = w_j & ~r_prev_j;

  // Direction next-state: only moves on a frame tick; opposing keys resolve to the newest press.
  always_comb begin
    w_state_nxt = r_state;
    if (i_tick) begin
      case ({w_l, w_r})
        2'b10:   w_state_nxt = S_LEFT;
        2'b01:   w_state_nxt = S_RIGHT;
        2'b00:   w_state_nxt = S_IDLE;
        default: begin
          if (w_l_new && !w_r_new)      w_state_nxt = S_LEFT;
          else if (w_r_new && !w_l_new) w_state_nxt = S_RIGHT;
          else if (w_l_new && w_r_new)  w_state_nxt = S_IDLE;
          else                          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Direction state, registered dir output and previous-tick key history.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_dir    <= 2'b00;
      r_prev_l <= 1'b0;
      r_prev_r <= 1'b0;
      r_prev_j <= 1'b0;
    end else if (i_tick) begin
      r_state  <= w_state_nxt;
      r_dir    <= w_state_nxt;
      r_prev_l <= w_l;
      r_prev_r <= w_r;
      r_prev_j <= w_j;
    end
  end

  // Jump buffer: a press arms a frame countdown; ack clears it, but a same-cycle press re-arms.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_jump_req <= 1'b0;
      r_cnt      <= 4'd0;
    end else if (i_tick && w_j_edge) begin
      r_jump_req <= 1'b1;
      r_cnt      <= BUF_LOAD;
    end else if (i_jump_ack) begin
      r_jump_req <= 1'b0;
      r_cnt      <= 4'd0;
    end else if (i_tick && r_jump_req) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) r_jump_req <= 1'b0;
    end
  end

  assign o_dir      = r_dir;
  assign o_jump_req = r_jump_req;

endmodule

// Top: frame_clk synchronizer plus one command lane per player.
module player_input_ctrl #(
  parameter logic [7:0]  P1_LEFT         = 8'h04,
  parameter logic [7:0]  P1_RIGHT        = 8'h07,
  parameter logic [7:0]  P1_JUMP         = 8'h1A,
  parameter logic [7:0]  P2_LEFT         = 8'h50,
  parameter logic [7:0]  P2_RIGHT        = 8'h4F,
  parameter logic [7:0]  P2_JUMP         = 8'h52,
  parameter int unsigned JUMP_BUF_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic       p1_jump_ack,
  input  logic       p2_jump_ack,
  output logic       frame_tick,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       p1_jump_req,
  output logic       p2_jump_req
);

  localparam int NUM_PLAYERS = 2;

  localparam logic [NUM_PLAYERS-1:0][7:0] LEFT_KC  = {P2_LEFT,  P1_LEFT};
  localparam logic [NUM_PLAYERS-1:0][7:0] RIGHT_KC = {P2_RIGHT, P1_RIGHT};
  localparam logic [NUM_PLAYERS-1:0][7:0] JUMP_KC  = {P2_JUMP,  P1_JUMP};

  logic [1:0] r_fs_pipe;
  logic       r_fs_d;
  logic       r_tick;

  logic [NUM_PLAYERS-1:0]      w_ack;
  logic [NUM_PLAYERS-1:0]      w_req;
  logic [NUM_PLAYERS-1:0][1:0] w_dir;

  // Two-flop synchronizer on frame_clk, then a registered rising-edge pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fs_pipe <= 2'b00;
      r_fs_d    <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_fs_pipe <= {r_fs_pipe[0], frame_clk};
      r_fs_d    <= r_fs_pipe[1];
      r_tick    <= r_fs_pipe[1] & ~r_fs_d;
    end
  end

  assign frame_tick = r_tick;
  assign w_ack      = {p2_jump_ack, p1_jump_ack};

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    player_input_lane #(
      .LEFT_KC         (LEFT_KC[g]),
      .RIGHT_KC        (RIGHT_KC[g]),
      .JUMP_KC         (JUMP_KC[g]),
      .JUMP_BUF_FRAMES (JUMP_BUF_FRAMES)
    ) u_lane (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_tick     (r_tick),
      .i_kc0      (keycode0),
      .i_kc1      (keycode1),
      .i_jump_ack (w_ack[g]),
      .o_dir      (w_dir[g]),
      .o_jump_req (w_req[g])
    );
  end

  assign p1_dir      = w_dir[0];
  assign p2_dir      = w_dir[1];
  assign p1_jump_req = w_req[0];
  assign p2_jump_req = w_req[1];

endmodule
